// File: rtl/bra_pkg.sv
// Shared definitions for the branch reservation station: compare opcodes,
// the "no lock" rename tag and the bit layout of the branch result word.
package bra_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NOP  = 3'd0,
        OP_BEQ  = 3'd1,
        OP_BNE  = 3'd2,
        OP_BLT  = 3'd3,
        OP_BGE  = 3'd4,
        OP_BLTU = 3'd5,
        OP_BGEU = 3'd6
    } bra_op_e;

    localparam int unsigned REG_NO_LOCK   = 0;

    localparam int unsigned RES_TAKEN_BIT = 0;
    localparam int unsigned RES_PRED_BIT  = 1;
    localparam int unsigned RES_MISP_BIT  = 2;
    localparam int unsigned RES_FLAGS_W   = 3;

    // Pack outcome, prediction and mispredict into the low result bits.
    function automatic logic [RES_FLAGS_W-1:0] bra_flags(input logic taken, input logic pred);
        logic [RES_FLAGS_W-1:0] f;
        f                = '0;
        f[RES_TAKEN_BIT] = taken;
        f[RES_PRED_BIT]  = pred;
        f[RES_MISP_BIT]  = taken ^ pred;
        return f;
    endfunction

endpackage

// File: rtl/branch_rs_param_if.sv
// Dispatch and CDB signal bundle between the issue logic (master) and the
// branch reservation station (slave).
interface branch_rs_param_if
    import bra_pkg::*;
#(
    parameter int unsigned ENTRIES = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LOCK_W  = 5,
    parameter int unsigned CNT_W   = $clog2(ENTRIES + 1)
);

    logic              bra_enable;
    logic [OP_W-1:0]   bra_op;
    logic              bra_pred;
    logic [DATA_W-1:0] bra_data1;
    logic [DATA_W-1:0] bra_data2;
    logic [LOCK_W-1:0] bra_lock1;
    logic [LOCK_W-1:0] bra_lock2;
    logic [LOCK_W-1:0] bra_rdlock;
    logic              bra_stall;
    logic [CNT_W-1:0]  bra_count;

    logic [LOCK_W-1:0] cdb_in_index;
    logic [DATA_W-1:0] cdb_in_result;

    logic              cdb_out_valid;
    logic              grnt;
    logic [LOCK_W-1:0] cdb_out_index;
    logic [DATA_W-1:0] cdb_out_result;

    modport master (
        output bra_enable, bra_op, bra_pred, bra_data1, bra_data2,
               bra_lock1, bra_lock2, bra_rdlock,
               cdb_in_index, cdb_in_result, grnt,
        input  bra_stall, bra_count, cdb_out_valid, cdb_out_index, cdb_out_result
    );

    modport slave (
        input  bra_enable, bra_op, bra_pred, bra_data1, bra_data2,
               bra_lock1, bra_lock2, bra_rdlock,
               cdb_in_index, cdb_in_result, grnt,
        output bra_stall, bra_count, cdb_out_valid, cdb_out_index, cdb_out_result
    );

endinterface

// File: rtl/bra_age_matrix.sv
// Insertion-order age matrix: age_q[i][j] set means entry i is older than j.
// Reports the oldest entry among the ready set as a one-hot vector.
module bra_age_matrix #(
    parameter int unsigned ENTRIES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic [ENTRIES-1:0] ins_oh_i,
    input  logic [ENTRIES-1:0] ready_i,
    output logic [ENTRIES-1:0] oldest_oh_c_o
);

    logic [ENTRIES-1:0] age_q [ENTRIES];
    logic [ENTRIES-1:0] age_d [ENTRIES];
    logic [ENTRIES-1:0] older_ready;

    // A new entry is younger than every other slot; stale bits of freed
    // slots are harmless because only ready rows are consulted.
    always_comb begin
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            age_d[i] = age_q[i];
        end
        for (int unsigned k = 0; k < ENTRIES; k++) begin
            if (ins_oh_i[k]) begin
                age_d[k] = '0;
                for (int unsigned i = 0; i < ENTRIES; i++) begin
                    if (i != k) begin
                        age_d[i][k] = 1'b1;
                    end
                end
            end
        end
        if (flush_i) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                age_d[i] = '0;
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            older_ready[i] = 1'b0;
            for (int unsigned j = 0; j < ENTRIES; j++) begin
                older_ready[i] = older_ready[i] | (ready_i[j] & age_q[j][i]);
            end
            oldest_oh_c_o[i] = ready_i[i] & ~older_ready[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

endmodule

// File: rtl/branch_rs_param.sv
// Branch reservation station: holds dispatched compares until both operands
// arrive over the CDB, then issues the oldest ready one through a result register.
module branch_rs_param
    import bra_pkg::*;
#(
    parameter int unsigned ENTRIES = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LOCK_W  = 5,
    parameter int unsigned CNT_W   = $clog2(ENTRIES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    branch_rs_param_if.slave bus
);

    bra_op_e           op_q     [ENTRIES];
    bra_op_e           op_d     [ENTRIES];
    logic              pred_q   [ENTRIES];
    logic              pred_d   [ENTRIES];
    logic [DATA_W-1:0] data1_q  [ENTRIES];
    logic [DATA_W-1:0] data1_d  [ENTRIES];
    logic [DATA_W-1:0] data2_q  [ENTRIES];
    logic [DATA_W-1:0] data2_d  [ENTRIES];
    logic [LOCK_W-1:0] lock1_q  [ENTRIES];
    logic [LOCK_W-1:0] lock1_d  [ENTRIES];
    logic [LOCK_W-1:0] lock2_q  [ENTRIES];
    logic [LOCK_W-1:0] lock2_d  [ENTRIES];
    logic [LOCK_W-1:0] rdlock_q [ENTRIES];
    logic [LOCK_W-1:0] rdlock_d [ENTRIES];

    logic              out_valid_q,  out_valid_d;
    logic [LOCK_W-1:0] out_index_q,  out_index_d;
    logic [DATA_W-1:0] out_result_q, out_result_d;
    logic [CNT_W-1:0]  count_q,      count_d;

    logic [ENTRIES-1:0] valid;
    logic [ENTRIES-1:0] ready;
    logic [ENTRIES-1:0] free_oh;
    logic [ENTRIES-1:0] ins_oh;
    logic [ENTRIES-1:0] oldest_oh;
    logic               free_found;
    logic               stall;
    logic               cdb_hit;
    logic               byp1;
    logic               byp2;
    logic               ins_en;
    logic               issue;
    bra_op_e            in_op;
    logic               sel_taken;
    logic               sel_pred;
    logic [LOCK_W-1:0]  sel_tag;
    logic [DATA_W-1:0]  sel_result;

    function automatic logic bra_taken(input bra_op_e op,
                                       input logic [DATA_W-1:0] a,
                                       input logic [DATA_W-1:0] b);
        logic t;
        t = 1'b0;
        case (op)
            OP_BEQ:  t = (a == b);
            OP_BNE:  t = (a != b);
            OP_BLT:  t = ($signed(a) <  $signed(b));
            OP_BGE:  t = ($signed(a) >= $signed(b));
            OP_BLTU: t = (a <  b);
            OP_BGEU: t = (a >= b);
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    assign in_op   = bra_op_e'(bus.bra_op);
    assign stall   = (count_q == CNT_W'(ENTRIES));
    assign cdb_hit = (bus.cdb_in_index != LOCK_W'(REG_NO_LOCK));
    assign byp1    = cdb_hit && (bus.bra_lock1 == bus.cdb_in_index);
    assign byp2    = cdb_hit && (bus.bra_lock2 == bus.cdb_in_index);
    // A NOP dispatch would occupy no entry, so it is not counted as an insert.
    assign ins_en  = bus.bra_enable && !stall && !flush && (in_op != OP_NOP);
    assign ins_oh  = free_oh & {ENTRIES{ins_en}};
    assign issue   = (|ready) && (!out_valid_q || bus.grnt);

    always_comb begin
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            valid[i] = (op_q[i] != OP_NOP);
            ready[i] = valid[i]
                    && (lock1_q[i] == LOCK_W'(REG_NO_LOCK))
                    && (lock2_q[i] == LOCK_W'(REG_NO_LOCK));
        end
    end

    // Lowest free slot; slots freed by this cycle's issue are still seen as busy.
    always_comb begin
        free_oh    = '0;
        free_found = 1'b0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (!valid[i] && !free_found) begin
                free_oh[i] = 1'b1;
                free_found = 1'b1;
            end
        end
    end

    bra_age_matrix #(
        .ENTRIES (ENTRIES)
    ) u_age (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush),
        .ins_oh_i      (ins_oh),
        .ready_i       (ready),
        .oldest_oh_c_o (oldest_oh)
    );

    always_comb begin
        sel_taken = 1'b0;
        sel_pred  = 1'b0;
        sel_tag   = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (oldest_oh[i]) begin
                sel_taken = bra_taken(op_q[i], data1_q[i], data2_q[i]);
                sel_pred  = pred_q[i];
                sel_tag   = rdlock_q[i];
            end
        end
        sel_result = DATA_W'(bra_flags(sel_taken, sel_pred));
    end

    // Entry update: wakeup, free on issue, insert with CDB bypass, flush last.
    always_comb begin
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            op_d[i]     = op_q[i];
            pred_d[i]   = pred_q[i];
            data1_d[i]  = data1_q[i];
            data2_d[i]  = data2_q[i];
            lock1_d[i]  = lock1_q[i];
            lock2_d[i]  = lock2_q[i];
            rdlock_d[i] = rdlock_q[i];
            if (valid[i] && cdb_hit && (lock1_q[i] == bus.cdb_in_index)) begin
                lock1_d[i] = LOCK_W'(REG_NO_LOCK);
                data1_d[i] = bus.cdb_in_result;
            end
            if (valid[i] && cdb_hit && (lock2_q[i] == bus.cdb_in_index)) begin
                lock2_d[i] = LOCK_W'(REG_NO_LOCK);
                data2_d[i] = bus.cdb_in_result;
            end
            if (issue && oldest_oh[i]) begin
                op_d[i] = OP_NOP;
            end
            if (ins_oh[i]) begin
                op_d[i]     = in_op;
                pred_d[i]   = bus.bra_pred;
                rdlock_d[i] = bus.bra_rdlock;
                data1_d[i]  = byp1 ? bus.cdb_in_result : bus.bra_data1;
                lock1_d[i]  = byp1 ? LOCK_W'(REG_NO_LOCK) : bus.bra_lock1;
                data2_d[i]  = byp2 ? bus.cdb_in_result : bus.bra_data2;
                lock2_d[i]  = byp2 ? LOCK_W'(REG_NO_LOCK) : bus.bra_lock2;
            end
            if (flush) begin
                op_d[i] = OP_NOP;
            end
        end
    end

    // Result register and occupancy count.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_index_d  = out_index_q;
        out_result_d = out_result_q;
        if (issue) begin
            out_valid_d  = 1'b1;
            out_index_d  = sel_tag;
            out_result_d = sel_result;
        end else if (bus.grnt) begin
            out_valid_d  = 1'b0;
        end
        if (flush) begin
            out_valid_d = 1'b0;
        end
        count_d = flush ? '0 : (count_q + CNT_W'(ins_en) - CNT_W'(issue));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                op_q[i]     <= OP_NOP;
                pred_q[i]   <= 1'b0;
                data1_q[i]  <= '0;
                data2_q[i]  <= '0;
                lock1_q[i]  <= '0;
                lock2_q[i]  <= '0;
                rdlock_q[i] <= '0;
            end
            out_valid_q  <= 1'b0;
            out_index_q  <= '0;
            out_result_q <= '0;
            count_q      <= '0;
        end else begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                op_q[i]     <= op_d[i];
                pred_q[i]   <= pred_d[i];
                data1_q[i]  <= data1_d[i];
                data2_q[i]  <= data2_d[i];
                lock1_q[i]  <= lock1_d[i];
                lock2_q[i]  <= lock2_d[i];
                rdlock_q[i] <= rdlock_d[i];
            end
            out_valid_q  <= out_valid_d;
            out_index_q  <= out_index_d;
            out_result_q <= out_result_d;
            count_q      <= count_d;
        end
    end

    assign bus.bra_stall      = stall;
    assign bus.bra_count      = count_q;
    assign bus.cdb_out_valid  = out_valid_q;
    assign bus.cdb_out_index  = out_index_q;
    assign bus.cdb_out_result = out_result_q;

endmodule

// File: tb/tb_branch_rs_param.sv
// Directed bench for branch_rs_param: expected CDB results are queued as the
// stimulus makes them determinable and checked in order as they are granted.
module tb_branch_rs_param;
    import bra_pkg::*;

    localparam int unsigned ENTRIES = 4;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned LOCK_W  = 5;
    localparam int unsigned CNT_W   = $clog2(ENTRIES + 1);

    typedef struct {
        logic [LOCK_W-1:0] idx;
        logic [DATA_W-1:0] res;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    branch_rs_param_if #(
        .ENTRIES (ENTRIES), .DATA_W (DATA_W), .LOCK_W (LOCK_W), .CNT_W (CNT_W)
    ) bus ();

    branch_rs_param #(
        .ENTRIES (ENTRIES), .DATA_W (DATA_W), .LOCK_W (LOCK_W), .CNT_W (CNT_W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_res(input logic [LOCK_W-1:0] idx, input logic [DATA_W-1:0] res);
        exp_t e;
        e.idx = idx;
        e.res = res;
        sb_q.push_back(e);
    endtask

    // Sample mid-cycle (1 time unit after the previous edge), then advance one clock.
    task automatic cycle();
        exp_t e;
        if (bus.cdb_out_valid === 1'b1 && bus.grnt === 1'b1) begin
            vectors++;
            assert (sb_q.size() != 0) else begin
                miscompares++;
                $error("FAIL unexpected_out: observed index %0h result %0h, required no output",
                       bus.cdb_out_index, bus.cdb_out_result);
            end
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("cdb_index",  DATA_W'(bus.cdb_out_index), DATA_W'(e.idx));
                chk("cdb_result", bus.cdb_out_result, e.res);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < max_cycles) begin
            cycle();
            n++;
        end
        vectors++;
        assert (sb_q.size() == 0) else begin
            miscompares++;
            $error("FAIL %s: observed %0d results pending, required 0", tag, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic insert(input bra_op_e op, input logic [DATA_W-1:0] d1, input logic [DATA_W-1:0] d2,
                          input logic [LOCK_W-1:0] l1, input logic [LOCK_W-1:0] l2,
                          input logic [LOCK_W-1:0] rd, input logic pred);
        bus.bra_enable = 1'b1;
        bus.bra_op     = op;
        bus.bra_data1  = d1;
        bus.bra_data2  = d2;
        bus.bra_lock1  = l1;
        bus.bra_lock2  = l2;
        bus.bra_rdlock = rd;
        bus.bra_pred   = pred;
        cycle();
        bus.bra_enable = 1'b0;
        bus.bra_op     = OP_NOP;
    endtask

    task automatic wake(input logic [LOCK_W-1:0] tag, input logic [DATA_W-1:0] val);
        bus.cdb_in_index  = tag;
        bus.cdb_in_result = val;
        cycle();
        bus.cdb_in_index  = '0;
        bus.cdb_in_result = '0;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [LOCK_W-1:0] idx,
                           input logic [DATA_W-1:0] res);
        chk({tag, "_valid"},  DATA_W'(bus.cdb_out_valid), DATA_W'(v));
        chk({tag, "_index"},  DATA_W'(bus.cdb_out_index), DATA_W'(idx));
        chk({tag, "_result"}, bus.cdb_out_result, res);
    endtask

    initial begin
        rst = 1'b0;
        flush = 1'b0;
        bus.bra_enable = 1'b0;  bus.bra_op = OP_NOP;  bus.bra_pred = 1'b0;
        bus.bra_data1 = '0;     bus.bra_data2 = '0;
        bus.bra_lock1 = '0;     bus.bra_lock2 = '0;   bus.bra_rdlock = '0;
        bus.cdb_in_index = '0;  bus.cdb_in_result = '0;
        bus.grnt = 1'b1;
        cycle();
        cycle();
        chk_out("reset", 1'b0, '0, '0);
        chk("reset_count", DATA_W'(bus.bra_count), 32'd0);
        chk("reset_stall", DATA_W'(bus.bra_stall), 32'd0);
        rst = 1'b1;

        // Ready BEQ: one cycle residency, then visible on the CDB.
        insert(OP_BEQ, 32'd5, 32'd5, 5'd0, 5'd0, 5'd3, 1'b0);
        chk("t32_count_ins", DATA_W'(bus.bra_count), 32'd1);
        chk("t32_valid_n",   DATA_W'(bus.cdb_out_valid), 32'd0);
        expect_res(5'd3, 32'h5);
        cycle();
        chk("t32_valid_n1",  DATA_W'(bus.cdb_out_valid), 32'd1);
        chk("t32_count_iss", DATA_W'(bus.bra_count), 32'd0);
        cycle();
        chk("t32_grnt_clear", DATA_W'(bus.cdb_out_valid), 32'd0);

        // Signed vs unsigned less-than with operand delivered by CDB.
        insert(OP_BLT, 32'd0, 32'd1, 5'd7, 5'd0, 5'd4, 1'b1);
        expect_res(5'd4, 32'h3);
        wake(5'd7, 32'hFFFF_FFFF);
        drain("t33_blt", 8);
        insert(OP_BLTU, 32'd0, 32'd1, 5'd7, 5'd0, 5'd5, 1'b1);
        expect_res(5'd5, 32'h6);
        wake(5'd7, 32'hFFFF_FFFF);
        drain("t33_bltu", 8);

        // Fill with blocked entries; a fifth dispatch must be dropped.
        for (int i = 0; i < 4; i++) begin
            insert(OP_BGEU, 32'd0, 32'h10, LOCK_W'(10 + i), 5'd0, LOCK_W'(20 + i), 1'b0);
        end
        chk("t34_stall_full", DATA_W'(bus.bra_stall), 32'd1);
        chk("t34_count_full", DATA_W'(bus.bra_count), 32'd4);
        insert(OP_BEQ, 32'd1, 32'd1, 5'd0, 5'd0, 5'd30, 1'b0);
        chk("t34_count_ignored", DATA_W'(bus.bra_count), 32'd4);
        cycle();
        cycle();
        chk("t34_no_out", DATA_W'(bus.cdb_out_valid), 32'd0);
        bus.grnt = 1'b0;
        wake(5'd12, 32'h20);
        chk("t34_stall_woken", DATA_W'(bus.bra_stall), 32'd1);
        cycle();
        chk_out("t34_issue", 1'b1, 5'd22, 32'h5);
        chk("t34_count_after", DATA_W'(bus.bra_count), 32'd3);
        chk("t34_stall_after", DATA_W'(bus.bra_stall), 32'd0);
        cycle();
        chk_out("t34_hold", 1'b1, 5'd22, 32'h5);

        // Flush with three entries and a held result, plus a competing dispatch.
        flush = 1'b1;
        bus.bra_enable = 1'b1;  bus.bra_op = OP_BEQ;  bus.bra_rdlock = 5'd31;
        bus.bra_lock1 = '0;     bus.bra_lock2 = '0;
        cycle();
        flush = 1'b0;
        bus.bra_enable = 1'b0;  bus.bra_op = OP_NOP;
        chk("t37_flush_count", DATA_W'(bus.bra_count), 32'd0);
        chk("t37_flush_valid", DATA_W'(bus.cdb_out_valid), 32'd0);
        chk("t37_flush_stall", DATA_W'(bus.bra_stall), 32'd0);
        bus.grnt = 1'b1;
        wake(5'd10, 32'h40);
        cycle();
        cycle();
        chk("t37_flush_quiet", DATA_W'(bus.cdb_out_valid), 32'd0);

        // Age order B, C, A with A blocked on tag 9, then a held output.
        insert(OP_BGE, 32'd0, 32'd0, 5'd9, 5'd0, 5'd1, 1'b0);
        expect_res(5'd2, 32'h6);
        expect_res(5'd6, 32'h3);
        insert(OP_BEQ, 32'd1, 32'd2, 5'd0, 5'd0, 5'd2, 1'b1);
        insert(OP_BNE, 32'd1, 32'd2, 5'd0, 5'd0, 5'd6, 1'b1);
        chk("t35_ins_iss_count", DATA_W'(bus.bra_count), 32'd2);
        cycle();
        expect_res(5'd1, 32'h5);
        wake(5'd9, 32'd5);
        bus.grnt = 1'b0;
        cycle();
        chk_out("t35_a_loaded", 1'b1, 5'd1, 32'h5);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk_out("t35_hold", 1'b1, 5'd1, 32'h5);
        end
        bus.grnt = 1'b1;
        drain("t35_order", 6);

        // Older entry in a higher slot must win over a younger one in slot 0.
        bus.grnt = 1'b0;
        insert(OP_BEQ, 32'd0, 32'd0, 5'd14, 5'd0, 5'd10, 1'b0);
        insert(OP_BNE, 32'd0, 32'd0, 5'd15, 5'd0, 5'd11, 1'b0);
        expect_res(5'd10, 32'h5);
        wake(5'd14, 32'd0);
        cycle();
        insert(OP_BEQ, 32'd0, 32'd7, 5'd16, 5'd0, 5'd12, 1'b1);
        expect_res(5'd11, 32'h5);
        wake(5'd15, 32'd3);
        expect_res(5'd12, 32'h3);
        wake(5'd16, 32'd7);
        bus.grnt = 1'b1;
        drain("t35_age_vs_index", 8);

        // Operand tag matches the CDB broadcast in the insert cycle.
        bus.cdb_in_index  = 5'd4;
        bus.cdb_in_result = 32'h77;
        insert(OP_BEQ, 32'd0, 32'h77, 5'd4, 5'd0, 5'd8, 1'b0);
        bus.cdb_in_index  = '0;
        bus.cdb_in_result = '0;
        expect_res(5'd8, 32'h5);
        drain("t36_bypass", 6);

        // Reset in the middle of activity drops everything.
        bus.grnt = 1'b0;
        insert(OP_BEQ, 32'd1, 32'd1, 5'd0, 5'd0, 5'd9, 1'b0);
        insert(OP_BEQ, 32'd2, 32'd2, 5'd0, 5'd0, 5'd13, 1'b0);
        insert(OP_BNE, 32'd2, 32'd2, 5'd17, 5'd0, 5'd18, 1'b0);
        chk("t37_pre_reset_valid", DATA_W'(bus.cdb_out_valid), 32'd1);
        rst = 1'b0;
        cycle();
        chk_out("t37_reset", 1'b0, '0, '0);
        chk("t37_reset_count", DATA_W'(bus.bra_count), 32'd0);
        chk("t37_reset_stall", DATA_W'(bus.bra_stall), 32'd0);
        rst = 1'b1;
        bus.grnt = 1'b1;
        wake(5'd17, 32'd1);
        for (int i = 0; i < 4; i++) begin
            cycle();
        end
        chk("t37_post_reset_quiet", DATA_W'(bus.cdb_out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $error("FAIL watchdog: observed simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
